// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, decode-bus entry layout and redirect selection for the fetch unit.
package ifetch_pkg;

    localparam int FS_TO_DS_BUS_WD = 65;
    localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;

    typedef struct packed {
        logic        excp;
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_entry_t;

    typedef enum logic [1:0] {RD_NONE, RD_BR, RD_ERTN, RD_EXCP} redir_t;

    function automatic redir_t redir_sel(input logic excp, input logic ertn, input logic br);
        return excp ? RD_EXCP : ertn ? RD_ERTN : br ? RD_BR : RD_NONE;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: power-of-two synchronous FIFO with synchronous clear, used for the buffer and the tag queue.
module ifetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rp, wp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign count   = cnt;
    assign dout    = mem[rp];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else if (clr) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wp] <= din;
    end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: in-order sram-like instruction fetch with credit-limited requests, buffer and redirect cancel.
// Define IFETCH_ADEF_EN to turn a misaligned fetch pc into a single excp entry followed by a halt.
module ifetch_unit import ifetch_pkg::*; #(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
    parameter int          IBUF_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ds_allowin,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    input  logic                       br_taken,
    input  logic [31:0]                br_target,
    input  logic                       excp_flush,
    input  logic                       ertn_flush,
    input  logic [31:0]                csr_eentry,
    input  logic [31:0]                csr_era,
    output logic                       inst_req,
    output logic                       inst_wr,
    output logic [1:0]                 inst_size,
    output logic [31:0]                inst_addr,
    output logic [3:0]                 inst_wstrb,
    output logic [31:0]                inst_wdata,
    input  logic                       inst_addr_ok,
    input  logic                       inst_data_ok,
    input  logic [31:0]                inst_rdata
);

    localparam int CW = $clog2(IBUF_DEPTH + 1) + 1;
    localparam int FW = $clog2(IBUF_DEPTH) + 1;

    logic [31:0]   pc, addr_hold, rd_target, tag_head;
    logic [CW-1:0] ot, cancel;
    logic          started, halt, req_hold, hold_cancel;
    logic          redirect, can_req, acc, acc_live, acc_dead, resp_live, resp_dead;
    logic          misalign, adef_push, buf_push, buf_pop;
    logic          buf_empty, buf_full, tag_empty, tag_full;
    logic [FW-1:0] buf_cnt, tag_cnt;
    fs_entry_t     buf_din, buf_dout;
    redir_t        rd_sel;

    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wstrb = 4'h0;
    assign inst_wdata = 32'h0;

    always_comb begin
        rd_sel    = redir_sel(excp_flush, ertn_flush, br_taken);
        rd_target = rd_sel == RD_EXCP ? csr_eentry : rd_sel == RD_ERTN ? csr_era : br_target;
        redirect  = rd_sel != RD_NONE;
    end

`ifdef IFETCH_ADEF_EN
    assign misalign  = pc[1:0] != 2'b00;
    assign adef_push = misalign && !halt && !req_hold && ot == '0 && !buf_full && !redirect;
    assign buf_din   = resp_live ? {1'b0, tag_head, inst_rdata} : {1'b1, pc, 32'h0};
`else
    assign misalign  = 1'b0;
    assign adef_push = 1'b0;
    assign buf_din   = {1'b0, tag_head, inst_rdata};
`endif

    // Buffer credit counts live requests; the bus limit also counts ones still owed to a cancel.
    assign can_req   = !halt && !req_hold && !misalign &&
                       (ot + CW'(buf_cnt)) < CW'(IBUF_DEPTH) &&
                       (ot + cancel) < CW'(MAX_OUTSTANDING);
    assign inst_req  = started && (req_hold || can_req);
    assign inst_addr = req_hold ? addr_hold : pc;
    assign acc       = inst_req && inst_addr_ok;
    assign acc_dead  = acc && (hold_cancel || redirect);
    assign acc_live  = acc && !acc_dead;
    assign resp_live = inst_data_ok && cancel == '0 && !redirect;
    assign resp_dead = inst_data_ok && cancel != '0;
    assign buf_push  = resp_live || adef_push;
    assign buf_pop   = !buf_empty && ds_allowin;

    assign fs_to_ds_valid = !buf_empty;
    assign fs_to_ds_bus   = buf_dout;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc          <= RESET_PC;
            addr_hold   <= RESET_PC;
            ot          <= '0;
            cancel      <= '0;
            halt        <= 1'b0;
            started     <= 1'b0;
            req_hold    <= 1'b0;
            hold_cancel <= 1'b0;
        end else begin
            started     <= 1'b1;
            req_hold    <= inst_req && !inst_addr_ok;
            hold_cancel <= inst_req && !inst_addr_ok && (hold_cancel || redirect);
            if (inst_req && !inst_addr_ok) addr_hold <= inst_addr;
            if (redirect) begin
                pc     <= rd_target;
                ot     <= '0;
                cancel <= cancel + ot + CW'(acc) - CW'(inst_data_ok);
                halt   <= 1'b0;
            end else begin
                if (acc_live) pc <= pc + 32'd4;
                if (adef_push) halt <= 1'b1;
                ot     <= ot + CW'(acc_live) - CW'(resp_live);
                cancel <= cancel + CW'(acc_dead) - CW'(resp_dead);
            end
        end
    end

    ifetch_fifo #(.W(FS_TO_DS_BUS_WD), .DEPTH(IBUF_DEPTH)) u_buf (
        .clk   (clk),
        .resetn(resetn),
        .clr   (redirect),
        .push  (buf_push),
        .din   (buf_din),
        .pop   (buf_pop),
        .dout  (buf_dout),
        .empty (buf_empty),
        .full  (buf_full),
        .count (buf_cnt)
    );

    ifetch_fifo #(.W(32), .DEPTH(IBUF_DEPTH)) u_tag (
        .clk   (clk),
        .resetn(resetn),
        .clr   (redirect),
        .push  (acc_live),
        .din   (inst_addr),
        .pop   (resp_live),
        .dout  (tag_head),
        .empty (tag_empty),
        .full  (tag_full),
        .count (tag_cnt)
    );

    always @(posedge clk) begin
        if (resetn) begin
            assert (!(buf_push && buf_full));
            assert (!(resp_live && tag_empty));
            assert (!(acc_live && tag_full));
            assert (CW'(tag_cnt) == ot);
        end
    end

endmodule
